// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin write arbiter in front of a four-entry 32-bit register bank.
// Each grant runs IDLE -> WRITE -> ACK; rd_data is a plain combinational read of the bank.
module reg_bank_arbiter (
  input  logic        clk,
  input  logic        res,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [1:0]  addr_a,
  input  logic [1:0]  addr_b,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  output logic        ack_a,
  output logic        ack_b,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        last_grant
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_next_state;
  logic        w_req_any;
  logic        w_grant_b;
  logic        r_win;
  logic [1:0]  r_addr;
  logic [31:0] r_data;
  logic        r_ack_a;
  logic        r_ack_b;
  logic        r_busy;
  logic        r_last_grant;
  logic [31:0] r_bank [4];

  assign w_req_any = req_a | req_b;

  // On a tie, serve whoever was not served last (r_last_grant = 1 means B went last).
  always_comb begin
    w_grant_b = 1'b0;
    if (req_a && req_b) begin
      w_grant_b = ~r_last_grant;
    end else begin
      w_grant_b = req_b;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WRITE: w_next_state = ST_ACK;
      ST_ACK:   w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Winner, address and data are captured at the grant edge so later input changes cannot leak in.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state      <= ST_IDLE;
      r_win        <= 1'b0;
      r_addr       <= 2'd0;
      r_data       <= 32'd0;
      r_ack_a      <= 1'b0;
      r_ack_b      <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
      r_ack_a <= (r_state == ST_WRITE) && !r_win;
      r_ack_b <= (r_state == ST_WRITE) && r_win;
      if ((r_state == ST_IDLE) && w_req_any) begin
        r_win        <= w_grant_b;
        r_addr       <= w_grant_b ? addr_b : addr_a;
        r_data       <= w_grant_b ? data_b : data_a;
        r_last_grant <= w_grant_b;
      end
    end
  end

  // The bank is only touched on the WRITE -> ACK edge; reset clears it and aborts any pending write.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < 4; i++) begin
        r_bank[i] <= 32'd0;
      end
    end else if (r_state == ST_WRITE) begin
      r_bank[r_addr] <= r_data;
    end
  end

  assign ack_a      = r_ack_a;
  assign ack_b      = r_ack_b;
  assign busy       = r_busy;
  assign last_grant = r_last_grant;
  assign rd_data    = r_bank[rd_addr];

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port res, input, 1 bit: asynchronous, active-high reset.
REQ-004 Ports req_a and req_b, inputs, 1 bit each: write request from requester A and requester B; held high until the matching ack.
REQ-005 Ports addr_a and addr_b, inputs, 2 bits each: target register index (0-3) for each requester.
REQ-006 Ports data_a and data_b, inputs, 32 bits each: write data for each requester.
REQ-007 Ports ack_a and ack_b, outputs, 1 bit each: one-cycle write-complete pulse to each requester.
REQ-008 Port rd_addr, input, 2 bits: read register index.
REQ-009 Port rd_data, output, 32 bits: contents of the register at rd_addr.
REQ-010 Port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 Port last_grant, output, 1 bit: 0 = A served last, 1 = B served last.

Function
REQ-012 The block SHALL hold four 32-bit registers, R0-R3, written only by this arbiter.
REQ-013 The FSM SHALL have exactly three states: IDLE, WRITE and ACK; encoding is free.
REQ-014 Request sampling: req_a and req_b SHALL be sampled only in IDLE; in WRITE and ACK they are ignored.
REQ-015 IDLE SHALL go to WRITE when req_a or req_b is high, and otherwise stay in IDLE.
REQ-016 Single request: the requester that is high SHALL be granted.
REQ-017 Both requests high: the requester not indicated by last_grant SHALL be granted (round-robin).
REQ-018 On the IDLE->WRITE edge, the winner id, its addr and its data SHALL be latched, and last_grant SHALL update to the winner.
REQ-019 Requester addr/data changes after the grant edge SHALL NOT affect the write.
REQ-020 WRITE SHALL go to ACK unconditionally; on that edge the latched data is written to R[latched addr].
REQ-021 ACK SHALL go to IDLE unconditionally.
REQ-022 In ACK, only the winner's ack SHALL be high; ack_a and ack_b SHALL never be high together.
REQ-023 The acks SHALL be registered and high for exactly one cycle per granted write.
REQ-024 Latency: req sampled in IDLE in cycle N → new value visible on rd_data in cycle N+2, ack in N+2, IDLE in N+3.
REQ-025 Back-to-back: a req still high in IDLE at N+3 SHALL be treated as a new request; requesters must drop req the cycle after ack.
REQ-026 rd_data SHALL be a combinational read of R[rd_addr], with no bypass of an in-flight write.
REQ-027 busy SHALL be high in WRITE and ACK, and low in IDLE.
REQ-028 Minimum spacing: a single requester SHALL see at most one ack per three cycles.

Reset
REQ-029 res high SHALL immediately, independent of clk, force: state IDLE; R0-R3 = 0x00000000; ack_a = ack_b = 0; busy = 0; last_grant = 1, so A wins the first tie.
REQ-030 Reset asserted in WRITE or ACK SHALL abort the write, with no ack issued and no register modified after reset.
REQ-031 After res deasserts, the first rising edge SHALL evaluate IDLE normally.

Verification
REQ-032 Reset then read: assert res, release; rd_addr = 0..3 → rd_data = 0x00000000 each; busy = 0; last_grant = 1.
REQ-033 Single write: req_a = 1, addr_a = 2, data_a = 0xDEADBEEF in cycle N → ack_a high in N+2 only, ack_b = 0 throughout; rd_addr = 2 gives 0xDEADBEEF from N+2.
REQ-034 Tie round-robin: after reset, req_a and req_b high together (A: addr 0, 0x11111111; B: addr 1, 0x22222222) and held until ack → A acked first, B acked three cycles later; R0 = 0x11111111, R1 = 0x22222222; last_grant ends at 1.
REQ-035 Data latching: req_b = 1, addr_b = 3, data_b = 0xCAFEF00D; change data_b to 0x0 and addr_b to 0 the cycle after grant → R3 = 0xCAFEF00D, R0 unchanged.
REQ-036 Reset mid-operation: grant req_a (addr 1, 0xAAAA5555), pulse res during WRITE → no ack_a, R1 = 0x00000000, state IDLE, busy = 0.
REQ-037 Ignored request: while busy, pulse req_b for one cycle only (low again by IDLE) → no ack_b and no register change.
